logic_sweep_tester: RTL and testbench
=====================================

// Module: logic_sweep_tester
// PURPOSE
//  Upstream stimulus/check stage for the logic_functions block: on start, drives all 8
//  {A,B,C} combinations into it in ascending order, waits a settle interval, samples O1..O4
//  and compares them against the golden equations. Reports per-vector failures and a
//  saturating mismatch count. Runs on the board as a self-test driven by a button.
// PARAMETERS
//  SETTLE_CYCLES  4  cycles spent in SETTLE per vector; 0 allowed (SETTLE skipped)
//  ERR_WIDTH      6  width of err_count; 6 holds the 32-mismatch worst case
// PORTS
//  clk           in   1          system clock; all state changes on rising edge
//  rst           in   1          synchronous, active-high reset
//  start         in   1          level-sampled request to begin a sweep
//  a, b, c       out  1 each     registered stimulus to logic_functions A, B, C
//  o1..o4        in   1 each     logic_functions outputs O1..O4
//  busy          out  1          high while a sweep is in progress
//  done          out  1          high from sweep end until next accepted start
//  pass          out  1          valid with done: 1 iff err_count==0
//  err_count     out  ERR_WIDTH  total mismatched output bits, saturating
//  mismatch_vec  out  8          bit v set if any output mismatched for vector v
// BEHAVIOUR
//  Reset (rst=1 at an edge, any state): state=IDLE, vec=0, a=b=c=0, busy=0, done=0,
//   pass=0, err_count=0, mismatch_vec=0. Reset wins over start on the same edge.
//  Vector encoding: vec[2:0]={a,b,c}. a,b,c load from vec on each edge entering APPLY.
//  Golden: O1=AC+A'B; O2=(A+C')BC; O3=AB'+C; O4=AB+B'C'.
//  FSM states IDLE, APPLY, SETTLE, CHECK, DONE:
//   IDLE/DONE: start=1 -> APPLY; vec=0; abc=000; err_count=0; mismatch_vec=0;
//    done=0; pass=0; busy=1. Otherwise hold all outputs.
//   APPLY: 1 cycle -> SETTLE (or CHECK if SETTLE_CYCLES=0).
//   SETTLE: exactly SETTLE_CYCLES cycles (down-counter) -> CHECK.
//   CHECK: 1 cycle; o1..o4 sampled at the edge leaving CHECK. n = number of outputs
//    differing from golden(vec), 0..4. err_count = min(err_count+n, 2**ERR_WIDTH-1).
//    mismatch_vec[vec] |= (n!=0). Then if vec==7 -> DONE (busy=0, done=1,
//    pass=(final err_count==0)); else vec=vec+1 (no wrap) -> APPLY.
//  start while busy is ignored; no queuing. start held high in DONE restarts immediately.
//  Latency: start accepted at edge k -> done=1 after edge k+8*(SETTLE_CYCLES+2).
//  a,b,c hold the last vector (111) in DONE; return to 000 only on restart or reset.
//  Saturation: err_count never wraps; pass stays 0 once saturated.
// TESTING
//  1 Real logic_functions attached, SETTLE_CYCLES=4, 1-cycle start -> done after 48
//    cycles; pass=1, err_count=0, mismatch_vec=8'h00; a,b,c stepped 000..111 in order.
//  2 O3 forced to 0 -> err_count=5, mismatch_vec=8'b1011_1010, pass=0.
//  3 All four outputs inverted -> err_count=32, mismatch_vec=8'hFF; repeat with
//    ERR_WIDTH=4 -> err_count=15 (saturated, no wrap).
//  4 start pulsed again mid-sweep -> ignored, done still at cycle 48; start from DONE ->
//    done=0, counts cleared same edge, new sweep done 48 cycles later.
//  5 rst asserted during SETTLE of vec=3 -> next cycle busy=0, abc=000, err_count=0,
//    mismatch_vec=0; rst with start high -> stays IDLE; later start -> full clean sweep.
//  6 SETTLE_CYCLES=0 -> done exactly 16 cycles after start accepted, pass=1.

Source files
------------

// File: rtl/logic_sweep_tester.sv
// Sweeps all eight {a,b,c} vectors into logic_functions and checks O1..O4 against the golden equations.
// Latency: done rises 8*(SETTLE_CYCLES+2) cycles after an accepted start.
// Backpressure: none; start is ignored while busy and is never queued.
module logic_sweep_tester #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_WIDTH     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    input  logic                 o1,
    input  logic                 o2,
    input  logic                 o3,
    input  logic                 o4,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [7:0]           mismatch_vec
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;
    localparam int SW = ERR_WIDTH + 3;
    localparam logic [ERR_WIDTH-1:0] ERR_MAX = {ERR_WIDTH{1'b1}};

    state_t         state;
    logic [2:0]     vec;
    logic [CW-1:0]  settle_cnt;

    logic           g1, g2, g3, g4;
    logic [3:0]     diff;
    logic [2:0]     n_err;
    logic [SW-1:0]  err_sum;
    logic [ERR_WIDTH-1:0] err_next;

    // Golden outputs are derived from vec, which a/b/c mirror throughout CHECK.
    always_comb begin
        g1 = (vec[2] & vec[0]) | (~vec[2] & vec[1]);
        g2 = (vec[2] | ~vec[0]) & vec[1] & vec[0];
        g3 = (vec[2] & ~vec[1]) | vec[0];
        g4 = (vec[2] & vec[1]) | (~vec[1] & ~vec[0]);
        diff = {o4 ^ g4, o3 ^ g3, o2 ^ g2, o1 ^ g1};
        n_err = {2'b00, diff[0]} + {2'b00, diff[1]} + {2'b00, diff[2]} + {2'b00, diff[3]};
        err_sum = SW'(err_count) + SW'(n_err);
        err_next = (err_sum > SW'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            vec          <= '0;
            settle_cnt   <= '0;
            a            <= 1'b0;
            b            <= 1'b0;
            c            <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            mismatch_vec <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_APPLY;
                        vec          <= '0;
                        {a, b, c}    <= 3'b000;
                        err_count    <= '0;
                        mismatch_vec <= '0;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                S_APPLY: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end
                end
                S_CHECK: begin
                    err_count         <= err_next;
                    mismatch_vec[vec] <= mismatch_vec[vec] | (n_err != 3'd0);
                    if (vec == 3'd7) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        vec       <= vec + 3'd1;
                        {a, b, c} <= vec + 3'd1;
                        state     <= S_APPLY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_sweep_tester.sv
// Directed bench: a truth-table model of logic_functions with injectable faults feeds three sweep testers.
module tb_logic_sweep_tester;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start_aux;
    logic [1:0] mode;

    logic [7:0] tab_o1 = 8'b1010_1100;
    logic [7:0] tab_o2 = 8'b1000_0000;
    logic [7:0] tab_o3 = 8'b1011_1010;
    logic [7:0] tab_o4 = 8'b1101_0001;

    int checks = 0;
    int failures = 0;

    // main instance: defaults, faultable model
    logic a_m, b_m, c_m, o1_m, o2_m, o3_m, o4_m, busy_m, done_m, pass_m;
    logic [5:0] err_m;
    logic [7:0] mvec_m;
    logic [2:0] v_m;
    logic inv_m;
    assign v_m   = {a_m, b_m, c_m};
    assign inv_m = (mode == 2'd2);
    assign o1_m  = tab_o1[v_m] ^ inv_m;
    assign o2_m  = tab_o2[v_m] ^ inv_m;
    assign o3_m  = (mode == 2'd1) ? 1'b0 : (tab_o3[v_m] ^ inv_m);
    assign o4_m  = tab_o4[v_m] ^ inv_m;

    // saturation instance: 4-bit counter, all outputs inverted
    logic a_s, b_s, c_s, busy_s, done_s, pass_s;
    logic [3:0] err_s;
    logic [7:0] mvec_s;
    logic [2:0] v_s;
    assign v_s = {a_s, b_s, c_s};

    // zero-settle instance, correct model
    logic a_f, b_f, c_f, busy_f, done_f, pass_f;
    logic [5:0] err_f;
    logic [7:0] mvec_f;
    logic [2:0] v_f;
    assign v_f = {a_f, b_f, c_f};

    logic_sweep_tester dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a_m), .b(b_m), .c(c_m),
        .o1(o1_m), .o2(o2_m), .o3(o3_m), .o4(o4_m),
        .busy(busy_m), .done(done_m), .pass(pass_m),
        .err_count(err_m), .mismatch_vec(mvec_m)
    );

    logic_sweep_tester #(.SETTLE_CYCLES(4), .ERR_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start_aux),
        .a(a_s), .b(b_s), .c(c_s),
        .o1(~tab_o1[v_s]), .o2(~tab_o2[v_s]), .o3(~tab_o3[v_s]), .o4(~tab_o4[v_s]),
        .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_count(err_s), .mismatch_vec(mvec_s)
    );

    logic_sweep_tester #(.SETTLE_CYCLES(0), .ERR_WIDTH(6)) dut_fast (
        .clk(clk), .rst(rst), .start(start_aux),
        .a(a_f), .b(b_f), .c(c_f),
        .o1(tab_o1[v_f]), .o2(tab_o2[v_f]), .o3(tab_o3[v_f]), .o4(tab_o4[v_f]),
        .busy(busy_f), .done(done_f), .pass(pass_f),
        .err_count(err_f), .mismatch_vec(mvec_f)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done; records each abc change.
    task automatic wait_done(output int cyc, output logic [20:0] seq, input int pulse_at);
        logic [2:0] last;
        cyc  = 0;
        seq  = '0;
        last = v_m;
        while (cyc < 200 && !done_m) begin
            @(negedge clk);
            cyc++;
            start = (cyc == pulse_at);
            if (v_m != last) begin
                seq  = {seq[17:0], v_m};
                last = v_m;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int cyc_s;
        int cyc_f;
        logic [20:0] seq;

        rst = 1'b1;
        start = 1'b0;
        start_aux = 1'b0;
        mode = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_done", 32'(done_m), 32'd0);
        check("rst_pass", 32'(pass_m), 32'd0);
        check("rst_abc", 32'(v_m), 32'd0);
        check("rst_err", 32'(err_m), 32'd0);
        check("rst_mvec", 32'(mvec_m), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // clean sweep
        start_pulse();
        check("t1_busy", 32'(busy_m), 32'd1);
        wait_done(cyc, seq, -1);
        check("t1_latency", 32'(cyc), 32'd48);
        check("t1_seq", 32'(seq), 32'(21'o1234567));
        check("t1_pass", 32'(pass_m), 32'd1);
        check("t1_err", 32'(err_m), 32'd0);
        check("t1_mvec", 32'(mvec_m), 32'h00);
        check("t1_busy_end", 32'(busy_m), 32'd0);
        check("t1_abc_hold", 32'(v_m), 32'd7);

        // O3 stuck low
        mode = 2'd1;
        start_pulse();
        wait_done(cyc, seq, -1);
        check("t2_latency", 32'(cyc), 32'd48);
        check("t2_err", 32'(err_m), 32'd5);
        check("t2_mvec", 32'(mvec_m), 32'hBA);
        check("t2_pass", 32'(pass_m), 32'd0);

        // all outputs inverted
        mode = 2'd2;
        start_pulse();
        wait_done(cyc, seq, -1);
        check("t3_err", 32'(err_m), 32'd32);
        check("t3_mvec", 32'(mvec_m), 32'hFF);
        check("t3_pass", 32'(pass_m), 32'd0);

        // restart from DONE clears on the accepting edge; mid-sweep start ignored
        mode = 2'd0;
        start_pulse();
        check("t4_done_clr", 32'(done_m), 32'd0);
        check("t4_busy", 32'(busy_m), 32'd1);
        check("t4_err_clr", 32'(err_m), 32'd0);
        check("t4_mvec_clr", 32'(mvec_m), 32'd0);
        check("t4_abc_clr", 32'(v_m), 32'd0);
        wait_done(cyc, seq, 20);
        check("t4_latency", 32'(cyc), 32'd48);
        check("t4_pass", 32'(pass_m), 32'd1);

        // reset during SETTLE of vector 3
        mode = 2'd1;
        start_pulse();
        repeat (12) @(negedge clk);
        check("t5_err_mid", 32'(err_m), 32'd1);
        repeat (8) @(negedge clk);
        check("t5_abc_mid", 32'(v_m), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 32'(busy_m), 32'd0);
        check("t5_abc", 32'(v_m), 32'd0);
        check("t5_err", 32'(err_m), 32'd0);
        check("t5_mvec", 32'(mvec_m), 32'd0);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("t5_rst_start_busy", 32'(busy_m), 32'd0);
        check("t5_rst_start_done", 32'(done_m), 32'd0);
        mode = 2'd0;
        start_pulse();
        wait_done(cyc, seq, -1);
        check("t5_latency", 32'(cyc), 32'd48);
        check("t5_seq", 32'(seq), 32'(21'o1234567));
        check("t5_pass", 32'(pass_m), 32'd1);

        // saturating 4-bit counter and zero-settle instance, run together
        start_aux = 1'b1;
        @(negedge clk);
        start_aux = 1'b0;
        cyc = 0;
        cyc_s = 0;
        cyc_f = 0;
        while (cyc < 200 && !(done_s && done_f)) begin
            @(negedge clk);
            cyc++;
            if (done_s && cyc_s == 0) cyc_s = cyc;
            if (done_f && cyc_f == 0) cyc_f = cyc;
        end
        check("t6_fast_latency", 32'(cyc_f), 32'd16);
        check("t6_fast_pass", 32'(pass_f), 32'd1);
        check("t6_fast_err", 32'(err_f), 32'd0);
        check("t3_sat_latency", 32'(cyc_s), 32'd48);
        check("t3_sat_err", 32'(err_s), 32'd15);
        check("t3_sat_mvec", 32'(mvec_s), 32'hFF);
        check("t3_sat_pass", 32'(pass_s), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
